// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm.
// One bit per cycle; ready/valid handshake on both input and output.
`timescale 1ns/1ps

module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    digits_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic             ovf_q;

  logic             neg;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    adj;

  // Unsigned negation keeps the most negative value exact (e.g. 0x8000 -> 32768).
  always_comb begin
    neg = (SIGNED != 0) && bin[WIDTH-1];
    mag = neg ? (~bin + WIDTH'(1)) : bin;
  end

  always_comb begin
    adj = digits_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      shreg_q     <= '0;
      digits_q    <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            shreg_q    <= mag;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= CW'(WIDTH);
            sign_q     <= neg;
            in_ready_q <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          digits_q <= {adj[BW-2:0], shreg_q[WIDTH-1]};
          shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
          // A carry out of the top digit means the magnitude no longer fits.
          ovf_q    <= ovf_q | adj[BW-1];
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd       = digits_q;
  assign sign      = sign_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three configurations (unsigned/5 digits, signed/5 digits,
// unsigned/4 digits) against a decimal reference model, plus a randomised stream.
`timescale 1ns/1ps

module tb_bin2bcd_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid [3];
  logic        out_ready[3];
  logic [15:0] bin      [3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        sign_w   [3];
  logic        ovf_w    [3];
  logic [19:0] bcd0, bcd1;
  logic [15:0] bcd2;

  int n_assert = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .bin(bin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .bcd(bcd0), .sign(sign_w[0]),
    .overflow(ovf_w[0])
  );
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .bin(bin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .bcd(bcd1), .sign(sign_w[1]),
    .overflow(ovf_w[1])
  );
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(0)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .bin(bin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .bcd(bcd2), .sign(sign_w[2]),
    .overflow(ovf_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] obs_bcd(input int idx);
    case (idx)
      0:       return bcd0;
      1:       return bcd1;
      default: return {4'h0, bcd2};
    endcase
  endfunction

  function automatic int cfg_digits(input int idx);
    return (idx == 2) ? 4 : 5;
  endfunction

  function automatic bit cfg_signed(input int idx);
    return idx == 1;
  endfunction

  // Reference model: plain decimal arithmetic on the magnitude.
  function automatic longint ref_mag(input int idx, input logic [15:0] v);
    if (cfg_signed(idx) && v[15]) return 65536 - longint'(v);
    return longint'(v);
  endfunction

  function automatic longint ref_limit(input int idx);
    longint lim = 1;
    for (int i = 0; i < cfg_digits(idx); i++) lim = lim * 10;
    return lim;
  endfunction

  function automatic logic [19:0] ref_bcd(input int idx, input logic [15:0] v);
    longint m = ref_mag(idx, v) % ref_limit(idx);
    logic [19:0] r = '0;
    for (int i = 0; i < cfg_digits(idx); i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int idx, input logic [15:0] v);
    return ref_mag(idx, v) >= ref_limit(idx);
  endfunction

  function automatic logic ref_sign(input int idx, input logic [15:0] v);
    return cfg_signed(idx) && v[15];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the instance idle; returns after the output handoff.
  task automatic convert(input int idx, input logic [15:0] val, input int hold);
    int cyc = 0;
    logic [19:0] eb = ref_bcd(idx, val);
    chk("in_ready_idle", 32'(in_ready[idx]), 32'd1);
    in_valid[idx] = 1'b1;
    bin[idx]      = val;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    bin[idx]      = 16'($urandom);
    while (!out_valid[idx] && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd16);
    chk("bcd", 32'(obs_bcd(idx)), 32'(eb));
    chk("sign", 32'(sign_w[idx]), 32'(ref_sign(idx, val)));
    chk("overflow", 32'(ovf_w[idx]), 32'(ref_ovf(idx, val)));
    chk("in_ready_busy", 32'(in_ready[idx]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid[idx] = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid[idx]), 32'd1);
      chk("hold_bcd", 32'(obs_bcd(idx)), 32'(eb));
      chk("hold_in_ready", 32'(in_ready[idx]), 32'd0);
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    chk("handoff_valid", 32'(out_valid[idx]), 32'd0);
    chk("handoff_in_ready", 32'(in_ready[idx]), 32'd1);
  endtask

  initial begin
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic [15:0] q[$];
    logic [15:0] v;

    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      bin[i]       = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_bcd", 32'(obs_bcd(i)), 32'd0);
      chk("rst_sign", 32'(sign_w[i]), 32'd0);
      chk("rst_ovf", 32'(ovf_w[i]), 32'd0);
    end

    // First acceptance on the first edge after reset release.
    reset_n = 1'b1;
    convert(0, 16'd0, 0);
    convert(0, 16'd65535, 10);
    convert(1, 16'h8000, 0);
    convert(1, 16'hFFFF, 0);
    convert(1, 16'd1234, 0);
    convert(2, 16'd12345, 0);
    convert(2, 16'd9999, 0);
    convert(2, 16'd10000, 0);

    // Abort a conversion mid-shift with a one-cycle reset.
    in_valid[0] = 1'b1;
    bin[0]      = 16'd4321;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_bcd", 32'(bcd0), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_valid", 32'(out_valid[0]), 32'd0);
      @(posedge clk); #1;
    end
    convert(0, 16'd42, 0);

    // Randomised stream with random in_valid/out_ready; in-order scoreboard.
    while (got < 1000 && cyc < 60000) begin
      in_valid[0]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bin[0]       = 16'($urandom);
      out_ready[0] = 1'($urandom_range(0, 1));
      if (in_valid[0] && in_ready[0]) begin
        q.push_back(bin[0]);
        sent++;
      end
      if (out_valid[0] && out_ready[0]) begin
        if (q.size() == 0) begin
          chk("stream_extra", 32'(q.size()), 32'd1);
        end else begin
          v = q.pop_front();
          chk("stream_bcd", 32'(bcd0), 32'(ref_bcd(0, v)));
          chk("stream_ovf", 32'(ovf_w[0]), 32'(ref_ovf(0, v)));
          chk("stream_sign", 32'(sign_w[0]), 32'd0);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    chk("stream_count", 32'(got), 32'd1000);
    chk("stream_leftover", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
